// File: rtl/rx_link_pkg.sv
// Shared definitions for the SERDES receive link controller: state encodings
// and default timing/threshold parameters.
package rx_link_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_SLIP    = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_RESYNC  = 3'd4
  } link_state_e;

  localparam int unsigned DEF_COMMA_LOCK = 4;
  localparam int unsigned DEF_HUNT_WORDS = 16;
  localparam int unsigned DEF_CONF_WORDS = 32;
  localparam int unsigned DEF_ERR_WINDOW = 64;
  localparam int unsigned DEF_ERR_MAX    = 4;
  localparam int unsigned DEF_STB_TMO    = 64;
  localparam int unsigned DEF_RST_CYC    = 8;
  localparam int unsigned DEF_CNT_W      = 16;

endpackage

// File: rtl/rx_err_window.sv
// Sliding word-window error monitor: trips when ERR_MAX errors land inside
// one ERR_WINDOW-word window. An error on the last word counts before the roll-over.
module rx_err_window
  import rx_link_pkg::*;
#(
  parameter int unsigned ERR_WINDOW = DEF_ERR_WINDOW,
  parameter int unsigned ERR_MAX    = DEF_ERR_MAX
) (
  input  logic clk,
  input  logic resetN,
  input  logic clr,
  input  logic stb,
  input  logic err,
  output logic trip
);

  localparam int unsigned WIN_W = $clog2(ERR_WINDOW + 1);
  localparam int unsigned ERR_W = $clog2(ERR_MAX + 1);

  logic [WIN_W-1:0] win_cnt;
  logic [ERR_W-1:0] win_err;
  logic             win_last;

  assign trip     = stb & err & (win_err == ERR_W'(ERR_MAX - 1));
  assign win_last = stb & (win_cnt == WIN_W'(ERR_WINDOW - 1));

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (clr || trip || win_last) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (stb) begin
      win_cnt <= win_cnt + WIN_W'(1);
      win_err <= win_err + ERR_W'(err);
    end
  end

endmodule

// File: rtl/rx_link_ctrl.sv
// Link-training and supervision controller for the SERDES receive path:
// comma hunt with bit slips, lock confirmation, error/stall supervision and write gating.
module rx_link_ctrl
  import rx_link_pkg::*;
#(
  parameter int unsigned COMMA_LOCK = DEF_COMMA_LOCK,
  parameter int unsigned HUNT_WORDS = DEF_HUNT_WORDS,
  parameter int unsigned CONF_WORDS = DEF_CONF_WORDS,
  parameter int unsigned ERR_WINDOW = DEF_ERR_WINDOW,
  parameter int unsigned ERR_MAX    = DEF_ERR_MAX,
  parameter int unsigned STB_TMO    = DEF_STB_TMO,
  parameter int unsigned RST_CYC    = DEF_RST_CYC,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             enable,
  input  logic             wordStb,
  input  logic             commaDet,
  input  logic             dataValid,
  input  logic             codeErr,
  input  logic             rdErr,
  input  logic             errClr,
  output logic             bitSlip,
  output logic             rxRestart,
  output logic             linkUp,
  output logic             dataWe,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] errCount
);

  localparam int unsigned HUNT_W = $clog2(HUNT_WORDS + 1);
  localparam int unsigned GAP_W  = $clog2(CONF_WORDS + 1);
  localparam int unsigned CC_W   = $clog2(COMMA_LOCK + 1);
  localparam int unsigned TMO_W  = $clog2(STB_TMO + 1);
  localparam int unsigned RST_W  = $clog2(RST_CYC + 1);

  link_state_e       st_q, st_d;
  logic [HUNT_W-1:0] hunt_q, hunt_d;
  logic [3:0]        slip_q, slip_d;
  logic [CC_W-1:0]   cc_q, cc_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [RST_W-1:0]  rst_q, rst_d;

  logic err, locked, win_trip, cnt_err;

  assign err     = wordStb & (codeErr | rdErr);
  assign locked  = (st_q == ST_LOCKED);
  assign cnt_err = enable & locked & err;

  rx_err_window #(
    .ERR_WINDOW (ERR_WINDOW),
    .ERR_MAX    (ERR_MAX)
  ) u_err_window (
    .clk    (clk),
    .resetN (resetN),
    .clr    (~enable | ~locked),
    .stb    (wordStb & locked),
    .err    (err),
    .trip   (win_trip)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      st_q   <= ST_HUNT;
      hunt_q <= '0;
      slip_q <= '0;
      cc_q   <= '0;
      gap_q  <= '0;
      tmo_q  <= '0;
      rst_q  <= '0;
    end else begin
      st_q   <= st_d;
      hunt_q <= hunt_d;
      slip_q <= slip_d;
      cc_q   <= cc_d;
      gap_q  <= gap_d;
      tmo_q  <= tmo_d;
      rst_q  <= rst_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    st_d   = st_q;
    hunt_d = '0;
    slip_d = slip_q;
    cc_d   = '0;
    gap_d  = '0;
    tmo_d  = '0;
    rst_d  = '0;

    unique case (st_q)
      ST_HUNT: begin
        hunt_d = hunt_q;
        if (wordStb) begin
          if (commaDet && !err) begin
            st_d   = ST_CONFIRM;
            cc_d   = CC_W'(1);
            hunt_d = '0;
          end else if (hunt_q == HUNT_W'(HUNT_WORDS - 1)) begin
            st_d   = ST_SLIP;
            hunt_d = '0;
          end else begin
            hunt_d = hunt_q + HUNT_W'(1);
          end
        end
      end

      // Ten consecutive slips cover every bit offset of a 10b word; give up and restart.
      ST_SLIP: begin
        if (slip_q == 4'd9) begin
          slip_d = '0;
          st_d   = ST_RESYNC;
        end else begin
          slip_d = slip_q + 4'd1;
          st_d   = ST_HUNT;
        end
      end

      ST_CONFIRM: begin
        cc_d  = cc_q;
        gap_d = gap_q;
        if (wordStb) begin
          if (err) begin
            st_d  = ST_HUNT;
            cc_d  = '0;
            gap_d = '0;
          end else if (commaDet) begin
            gap_d = '0;
            if (cc_q == CC_W'(COMMA_LOCK - 1)) begin
              st_d = ST_LOCKED;
              cc_d = '0;
            end else begin
              cc_d = cc_q + CC_W'(1);
            end
          end else if (gap_q == GAP_W'(CONF_WORDS - 1)) begin
            st_d  = ST_HUNT;
            cc_d  = '0;
            gap_d = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      ST_LOCKED: begin
        slip_d = '0;
        tmo_d  = wordStb ? '0 : tmo_q + TMO_W'(1);
        if (win_trip || (!wordStb && tmo_q == TMO_W'(STB_TMO - 1))) begin
          st_d  = ST_RESYNC;
          tmo_d = '0;
        end
      end

      ST_RESYNC: begin
        slip_d = '0;
        if (rst_q == RST_W'(RST_CYC - 1)) begin
          st_d = ST_HUNT;
        end else begin
          rst_d = rst_q + RST_W'(1);
        end
      end

      default: st_d = ST_HUNT;
    endcase

    if (!enable) begin
      st_d   = ST_HUNT;
      hunt_d = '0;
      slip_d = '0;
      cc_d   = '0;
      gap_d  = '0;
      tmo_d  = '0;
      rst_d  = '0;
    end
  end

  // errClr wins over an accumulated count but still records an error arriving with it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      errCount <= '0;
      dataWe   <= 1'b0;
    end else begin
      dataWe <= enable & wordStb & dataValid & ~codeErr & ~rdErr & locked;
      if (!enable) begin
        errCount <= '0;
      end else if (errClr) begin
        errCount <= CNT_W'(cnt_err);
      end else if (cnt_err && (errCount != '1)) begin
        errCount <= errCount + CNT_W'(1);
      end
    end
  end

  assign state     = st_q;
  assign bitSlip   = (st_q == ST_SLIP);
  assign rxRestart = (st_q == ST_RESYNC);
  assign linkUp    = locked;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Self-checking bench for rx_link_ctrl: table-driven training vectors, hand-written
// corner sequences, and a dataWe scoreboard fed at drive time.
module tb_rx_link_ctrl;
  import rx_link_pkg::*;

  logic        clk = 1'b0;
  logic        resetN, enable, wordStb, commaDet, dataValid, codeErr, rdErr, errClr;
  logic        bitSlip, rxRestart, linkUp, dataWe;
  logic [2:0]  state;
  logic [15:0] errCount;

  int checks   = 0;
  int failures = 0;
  int slip_seen = 0;
  bit m_locked = 1'b0;
  bit exp_we_q[$];

  typedef struct packed {
    bit       stb;
    bit       comma;
    bit       dv;
    bit       ce;
    bit       rd;
    bit [2:0] st;
    bit       link;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  always #5 clk = ~clk;

  rx_link_ctrl dut (
    .clk       (clk),
    .resetN    (resetN),
    .enable    (enable),
    .wordStb   (wordStb),
    .commaDet  (commaDet),
    .dataValid (dataValid),
    .codeErr   (codeErr),
    .rdErr     (rdErr),
    .errClr    (errClr),
    .bitSlip   (bitSlip),
    .rxRestart (rxRestart),
    .linkUp    (linkUp),
    .dataWe    (dataWe),
    .state     (state),
    .errCount  (errCount)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, push the expected write strobe, sample #1 after the edge.
  task automatic step(input bit stb, input bit comma, input bit dv, input bit ce,
                      input bit rd, input bit clr = 1'b0);
    wordStb = stb; commaDet = comma; dataValid = dv; codeErr = ce; rdErr = rd; errClr = clr;
    exp_we_q.push_back(m_locked & enable & stb & dv & ~ce & ~rd);
    @(posedge clk);
    #1;
    wordStb = 0; commaDet = 0; dataValid = 0; codeErr = 0; rdErr = 0; errClr = 0;
    if (bitSlip) slip_seen++;
    check("dataWe", {31'd0, dataWe}, {31'd0, exp_we_q.pop_front()});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic lock_up(input string tag);
    repeat (4) step(1, 1, 0, 0, 0);
    check({tag, "_state"}, state, ST_LOCKED);
    check({tag, "_linkUp"}, linkUp, 1);
    m_locked = 1'b1;
  endtask

  function automatic vec_t v(input bit stb, input bit comma, input bit dv, input bit ce,
                             input bit rd, input bit [2:0] st, input bit link);
    return {stb, comma, dv, ce, rd, st, link};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi;
    resetN = 0; enable = 0; wordStb = 0; commaDet = 0; dataValid = 0;
    codeErr = 0; rdErr = 0; errClr = 0;

    //           stb comma dv ce rd  state link
    tbl[0]  = v(1, 1, 0, 0, 0, 3'd2, 0);
    tbl[1]  = v(1, 1, 0, 0, 0, 3'd2, 0);
    tbl[2]  = v(1, 1, 0, 1, 0, 3'd0, 0);
    tbl[3]  = v(1, 0, 1, 0, 0, 3'd0, 0);
    tbl[4]  = v(1, 1, 0, 0, 1, 3'd0, 0);
    tbl[5]  = v(0, 1, 1, 0, 0, 3'd0, 0);
    tbl[6]  = v(1, 1, 0, 0, 0, 3'd2, 0);
    tbl[7]  = v(1, 0, 1, 0, 0, 3'd2, 0);
    tbl[8]  = v(1, 1, 0, 0, 0, 3'd2, 0);
    tbl[9]  = v(0, 0, 0, 0, 0, 3'd2, 0);
    tbl[10] = v(1, 1, 0, 0, 0, 3'd2, 0);
    tbl[11] = v(1, 1, 0, 0, 0, 3'd3, 1);
    tbl[12] = v(1, 0, 1, 0, 0, 3'd3, 1);
    tbl[13] = v(1, 0, 1, 0, 1, 3'd3, 1);
    tbl[14] = v(1, 0, 1, 1, 0, 3'd3, 1);
    tbl[15] = v(0, 0, 0, 0, 0, 3'd3, 1);
    tbl[16] = v(1, 0, 1, 0, 0, 3'd3, 1);

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state, ST_HUNT);
    check("rst_outputs", {bitSlip, rxRestart, linkUp, dataWe}, 4'b0000);
    check("rst_errCount", errCount, 0);
    resetN = 1;
    enable = 1;
    @(posedge clk);
    #1;

    // Training table: partial confirm aborted by codeErr, re-hunt, lock, write gating.
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].stb, tbl[i].comma, tbl[i].dv, tbl[i].ce, tbl[i].rd);
      check($sformatf("vec%0d_state", i), state, tbl[i].st);
      check($sformatf("vec%0d_linkUp", i), linkUp, tbl[i].link);
      m_locked = (tbl[i].st == 3'd3);
    end
    check("table_errCount", errCount, 2);

    enable = 0;
    idle();
    m_locked = 1'b0;
    check("disable_state", state, ST_HUNT);
    check("disable_errCount", errCount, 0);
    enable = 1;

    // Four rdErr words back to back trip RESYNC; dropping enable ends it next cycle.
    lock_up("lockB");
    repeat (3) step(1, 0, 1, 0, 1);
    check("err3_state", state, ST_LOCKED);
    step(1, 0, 1, 0, 1);
    m_locked = 1'b0;
    check("err4_state", state, ST_RESYNC);
    check("err4_linkUp", linkUp, 0);
    check("err4_rxRestart", rxRestart, 1);
    check("err4_errCount", errCount, 4);
    idle();
    idle();
    check("resync_hold", rxRestart, 1);
    enable = 0;
    idle();
    check("en_drop_rxRestart", rxRestart, 0);
    check("en_drop_state", state, ST_HUNT);
    enable = 1;

    // Window boundaries: 3 errors at the end of one window and 3 at the start of
    // the next stay up; a 4th on the last word of a window trips.
    lock_up("lockC");
    for (int w = 0; w < 64; w++) step(1, 0, 1, 0, w >= 61);
    check("win1_state", state, ST_LOCKED);
    check("win1_errCount", errCount, 3);
    for (int w = 0; w < 64; w++) step(1, 0, 1, 0, w < 3);
    check("win2_state", state, ST_LOCKED);
    check("win2_errCount", errCount, 6);
    for (int w = 0; w < 63; w++) step(1, 0, 1, 0, w < 3);
    check("win3_pre_state", state, ST_LOCKED);
    step(1, 0, 1, 0, 1);
    m_locked = 1'b0;
    check("win3_trip_state", state, ST_RESYNC);
    check("win3_errCount", errCount, 10);
    for (int n = 0; n < 20 && rxRestart; n++) idle();
    check("win3_done_state", state, ST_HUNT);

    // errCount survives RESYNC; errClr together with an error leaves 1.
    lock_up("lockD");
    check("relock_errCount", errCount, 10);
    step(1, 0, 1, 0, 1, 1);
    check("clr_err_errCount", errCount, 1);
    step(0, 0, 0, 0, 0, 1);
    check("clr_errCount", errCount, 0);

    // Word-strobe stall: 63 idle cycles keep lock, the 64th drops it.
    step(1, 0, 1, 0, 0);
    repeat (63) idle();
    check("stall63_state", state, ST_LOCKED);
    check("stall63_linkUp", linkUp, 1);
    idle();
    m_locked = 1'b0;
    check("stall64_state", state, ST_RESYNC);
    check("stall64_linkUp", linkUp, 0);
    check("stall64_rxRestart", rxRestart, 1);

    // Asynchronous reset mid-RESYNC clears outputs without waiting for a clock.
    idle();
    #2;
    resetN = 0;
    #1;
    check("async_rst_state", state, ST_HUNT);
    check("async_rst_outputs", {bitSlip, rxRestart, linkUp, dataWe}, 4'b0000);
    @(posedge clk);
    #1;
    resetN = 1;

    // Hunt timeout: 16 non-comma words give one slip; the 10th slip restarts for 8 cycles.
    slip_seen = 0;
    for (int s = 0; s < 10; s++) begin
      for (int w = 0; w < 16; w++) begin
        step(1, 0, 1, 0, 0);
        if (s == 0 && w == 14) begin
          check("hunt15_state", state, ST_HUNT);
          check("hunt15_bitSlip", bitSlip, 0);
        end
      end
      check($sformatf("slip%0d_state", s), state, ST_SLIP);
      check($sformatf("slip%0d_bitSlip", s), bitSlip, 1);
      idle();
      if (s < 9) begin
        check($sformatf("slip%0d_after", s), {state, bitSlip}, {ST_HUNT, 1'b0});
      end else begin
        check("slip9_after_state", state, ST_RESYNC);
      end
    end
    check("slip_pulses", slip_seen, 10);
    hi = rxRestart ? 1 : 0;
    for (int n = 0; n < 20; n++) begin
      idle();
      if (!rxRestart) break;
      hi++;
    end
    check("rxRestart_cycles", hi, 8);
    check("post_restart_state", state, ST_HUNT);

    // CONFIRM gap limit: 31 non-comma words tolerated, the 32nd falls back.
    step(1, 1, 0, 0, 0);
    repeat (31) step(1, 0, 1, 0, 0);
    check("gap31_state", state, ST_CONFIRM);
    step(1, 0, 1, 0, 0);
    check("gap32_state", state, ST_HUNT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
